req_ack_initiator: RTL and testbench
====================================

REQ_ACK_INITIATOR -- requirements
Module: req_ack_initiator

Interface
REQ-001 Parameter DW, default 8, command payload width in bits.
REQ-002 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 Parameter MAX_LAT, default 5, last cycle after req in which ack is accepted (>=1).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  upstream command present.
REQ-007 cmd_data  input  DW  upstream command payload.
REQ-008 cmd_ready  output  1  FIFO can accept a command; transfer when cmd_valid && cmd_ready at posedge.
REQ-009 req  output  1  single-cycle request pulse to responder.
REQ-010 req_data  output  DW  payload of current request, stable from req cycle until done/timeout.
REQ-011 ack  input  1  responder acknowledge, single-cycle pulse.
REQ-012 done  output  1  one-cycle pulse: current request acknowledged.
REQ-013 timeout  output  1  one-cycle pulse: request dropped, no ack within window.
REQ-014 spurious_ack  output  1  one-cycle pulse: ack outside any valid window.
REQ-015 busy  output  1  high in REQ or WAIT state.
REQ-016 pending_cnt  output  $clog2(DEPTH+1)  commands held in FIFO.

Function
REQ-017 FSM states IDLE, REQ, WAIT; req = 1 only in REQ, REQ lasts exactly one cycle.
REQ-018 IDLE -> REQ at next edge when FIFO non-empty; head popped into req_data on that edge.
REQ-019 REQ -> WAIT unconditionally; latency counter loads 1 on entry to WAIT.
REQ-020 With req high in cycle T, ack sampled in cycle T+k, 1<=k<=MAX_LAT, ends the transaction; done = 1 in cycle T+k+1.
REQ-021 On accepted ack, next state is REQ if FIFO non-empty (req in T+k+1, concurrent with done), else IDLE; req is therefore never high two consecutive cycles.
REQ-022 No ack through cycle T+MAX_LAT: timeout = 1 in cycle T+MAX_LAT+1, command dropped, next state per REQ-021.
REQ-023 ack sampled in IDLE, or in REQ (zero latency), raises spurious_ack next cycle and does not change state.
REQ-024 ack arriving in timeout cycle T+MAX_LAT+1 is spurious.
REQ-025 At most one request outstanding; no new req before done or timeout.
REQ-026 cmd_ready = !full, registered; push and pop in same cycle permitted, pending_cnt unchanged.
REQ-027 Push when full never occurs (ready low); FIFO pointers wrap modulo DEPTH.
REQ-028 Commands issued in strict FIFO order.

Reset
REQ-029 rst_n low: state IDLE, FIFO empty, req, done, timeout, spurious_ack, busy, cmd_ready = 0, pending_cnt = 0, req_data = 0.
REQ-030 cmd_ready rises at first posedge after rst_n deasserts.
REQ-031 Reset mid-transaction abandons it with no done or timeout pulse; ack in first post-reset cycle counts as spurious.

Configuration
REQ-032 Macro REQ_ACK_RETRY_EN defined: on window expiry the same req_data is reissued (req in T+MAX_LAT+1) up to 2 retries; timeout pulses only after the third expiry; done pulses on ack of any attempt.
REQ-033 REQ_ACK_RETRY_EN undefined: no retry logic, timeout on first expiry per REQ-022.

Verification
REQ-034 Push 0xA5 after reset, ack 2 cycles after req -> one req pulse, req_data 0xA5, done one cycle after ack, busy low afterwards.
REQ-035 Push 0x11,0x22,0x33 back-to-back, ack at k=5 each -> three reqs in order, each next req coincident with previous done, no timeout.
REQ-036 Push 0x44, never ack -> timeout at T+MAX_LAT+1 (T+6), no done; with REQ_ACK_RETRY_EN, req at T, T+6, T+12, timeout at T+18.
REQ-037 ack pulse in IDLE and ack at same cycle as req -> spurious_ack next cycle each time, transaction still completes on later valid ack.
REQ-038 Push DEPTH commands with no ack -> cmd_ready low when full, pending_cnt = DEPTH-1 after first pop, resumes high on next pop.
REQ-039 rst_n low during WAIT, then ack -> no done, spurious_ack after reset release, all outputs at reset values.

Source files
------------

// File: rtl/req_ack_if.sv
// Command-in / request-out handshake bundle for req_ack_initiator.
// The initiator drives through the master modport; the environment uses slave.
interface req_ack_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          cmd_valid;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic          req;
  logic [DW-1:0] req_data;
  logic          ack;
  logic          done;
  logic          timeout;
  logic          spurious_ack;
  logic          busy;
  logic [CW-1:0] pending_cnt;

  modport master (
    input  cmd_valid, cmd_data, ack,
    output cmd_ready, req, req_data, done, timeout, spurious_ack, busy, pending_cnt
  );

  modport slave (
    output cmd_valid, cmd_data, ack,
    input  cmd_ready, req, req_data, done, timeout, spurious_ack, busy, pending_cnt
  );
endinterface

// File: rtl/req_ack_initiator.sv
// Command FIFO feeding a one-outstanding req/ack initiator with a bounded ack window.
// Define REQ_ACK_RETRY_EN to reissue an unacknowledged request up to two more times.
module req_ack_initiator #(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int MAX_LAT = 5
) (
  input logic       clk,
  input logic       rst_n,
  req_ack_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [LW-1:0] LAT_MAX  = LW'(MAX_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_cmd_ready;
  logic [LW-1:0] r_lat;
  logic [DW-1:0] r_req_data;
  logic          r_done, r_timeout, r_spurious;

  logic w_push, w_pop, w_empty, w_finish;
  logic w_done_set, w_timeout_set, w_spurious_set;

`ifdef REQ_ACK_RETRY_EN
  localparam logic [1:0] MAX_RETRY = 2'd2;
  logic [1:0] r_retry;
  logic       w_reissue;
`endif

  assign w_push  = bus.cmd_valid && r_cmd_ready;
  assign w_empty = (r_count == '0);

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_finish       = 1'b0;
    w_done_set     = 1'b0;
    w_timeout_set  = 1'b0;
    w_spurious_set = 1'b0;
`ifdef REQ_ACK_RETRY_EN
    w_reissue      = 1'b0;
`endif

    unique case (r_state)
      ST_IDLE: begin
        w_spurious_set = bus.ack;
        if (!w_empty) begin
          w_state_nxt = ST_REQ;
          w_pop       = 1'b1;
        end
      end
      ST_REQ: begin
        // Zero-latency ack is outside the window.
        w_spurious_set = bus.ack;
        w_state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.ack) begin
          w_done_set = 1'b1;
          w_finish   = 1'b1;
        end else if (r_lat == LAT_MAX) begin
`ifdef REQ_ACK_RETRY_EN
          if (r_retry < MAX_RETRY) begin
            w_reissue   = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_timeout_set = 1'b1;
            w_finish      = 1'b1;
          end
`else
          w_timeout_set = 1'b1;
          w_finish      = 1'b1;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Closing a transaction chains straight into the next queued command.
    if (w_finish) begin
      if (!w_empty) begin
        w_state_nxt = ST_REQ;
        w_pop       = 1'b1;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
      r_lat       <= '0;
      r_req_data  <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != FULL_CNT);
      r_done      <= w_done_set;
      r_timeout   <= w_timeout_set;
      r_spurious  <= w_spurious_set;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_req_data <= r_mem[r_rd_ptr];
      end
      if (r_state == ST_REQ)       r_lat <= LW'(1);
      else if (r_state == ST_WAIT) r_lat <= r_lat + LW'(1);
    end
  end

  // NOTE: FIFO storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.cmd_data;
  end

`ifdef REQ_ACK_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_retry <= '0;
    else if (w_pop)     r_retry <= '0;
    else if (w_reissue) r_retry <= r_retry + 2'd1;
  end
`endif

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.req          = (r_state == ST_REQ);
  assign bus.req_data     = r_req_data;
  assign bus.done         = r_done;
  assign bus.timeout      = r_timeout;
  assign bus.spurious_ack = r_spurious;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.pending_cnt  = r_count;
endmodule

// File: tb/tb_req_ack_initiator.sv
// Directed bench for req_ack_initiator: a scoreboard queue holds expected req_data
// in issue order and a negedge monitor pops it on every req pulse.
module tb_req_ack_initiator;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int MAX_LAT = 5;
`ifdef REQ_ACK_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_req = 0;
  int   last_req_cyc = 0;
  logic prev_req = 1'b0;
  logic [DW-1:0] exp_q[$];

  req_ack_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  req_ack_initiator #(.DW(DW), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every req pulse must carry the oldest expected payload.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req) begin
        check("req_not_back_to_back", prev_req, 0);
        check("req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("req_data_order", bus.req_data, exp_q.pop_front());
        n_req++;
        last_req_cyc = cyc;
      end
      prev_req = bus.req;
    end else begin
      prev_req = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // NOTE: the bench drives inputs with blocking assignments 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic push(input logic [DW-1:0] data, input int reps);
    int g = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = data;
    while (!bus.cmd_ready && g < 100) begin
      step();
      g++;
    end
    check("push_ready", bus.cmd_ready, 1);
    step();
    bus.cmd_valid = 1'b0;
    repeat (reps) exp_q.push_back(data);
  endtask

  task automatic wait_req(input int goal);
    int g = 0;
    while (n_req < goal && g < 100) begin
      step();
      g++;
    end
    check("req_arrived", n_req >= goal, 1);
  endtask

  // Ack in cycle T+k of request number goal; returns in cycle T+k+1.
  task automatic ack_at(input int goal, input int k);
    wait_req(goal);
    step_to(last_req_cyc + k);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ack = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int base;
    int t0;
    int g;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.ack       = 1'b0;

    // Reset values, then cmd_ready at the first edge after release.
    repeat (3) step();
    check("rst_req", bus.req, 0);
    check("rst_done", bus.done, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_spurious", bus.spurious_ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_pending", bus.pending_cnt, 0);
    check("rst_req_data", bus.req_data, 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", bus.cmd_ready, 1);

    // Single command, ack at k=2.
    base = n_req;
    push(8'hA5, 1);
    check("t1_pending", bus.pending_cnt, 1);
    ack_at(base + 1, 2);
    check("t1_done", bus.done, 1);
    check("t1_busy_after", bus.busy, 0);
    check("t1_no_timeout", bus.timeout, 0);
    check("t1_req_count", n_req, base + 1);
    step();
    check("t1_done_pulse", bus.done, 0);

    // Three back-to-back commands, ack at k=5; next req coincides with done.
    base = n_req;
    push(8'h11, 1);
    push(8'h22, 1);
    push(8'h33, 1);
    ack_at(base + 1, 5);
    check("t2_done1", bus.done, 1);
    check("t2_req2", bus.req, 1);
    check("t2_to1", bus.timeout, 0);
    ack_at(base + 2, 5);
    check("t2_done2", bus.done, 1);
    check("t2_req3", bus.req, 1);
    check("t2_to2", bus.timeout, 0);
    ack_at(base + 3, 5);
    check("t2_done3", bus.done, 1);
    check("t2_req_end", bus.req, 0);
    check("t2_busy_end", bus.busy, 0);
    check("t2_to3", bus.timeout, 0);

    // No ack: retries (if built in), then timeout; ack in timeout cycle is spurious.
    base = n_req;
    push(8'h44, RETRIES + 1);
    wait_req(base + 1);
    t0 = last_req_cyc;
    for (int a = 1; a <= RETRIES; a++) begin
      step_to(t0 + a * (MAX_LAT + 1));
      check("t3_reissue_req", bus.req, 1);
      check("t3_reissue_no_to", bus.timeout, 0);
    end
    step_to(t0 + (RETRIES + 1) * (MAX_LAT + 1));
    check("t3_timeout", bus.timeout, 1);
    check("t3_no_done", bus.done, 0);
    check("t3_busy", bus.busy, 0);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("t3_ack_in_to_cycle", bus.spurious_ack, 1);
    check("t3_to_pulse", bus.timeout, 0);
    check("t3_req_count", n_req, base + RETRIES + 1);

    // Ack in IDLE, then ack in the REQ cycle, then a valid ack.
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("t4_idle_spurious", bus.spurious_ack, 1);
    check("t4_idle_busy", bus.busy, 0);
    base = n_req;
    push(8'h66, 1);
    g = 0;
    while (!bus.req && g < 20) begin
      step();
      g++;
    end
    check("t4_req_seen", bus.req, 1);
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("t4_zero_lat_spurious", bus.spurious_ack, 1);
    check("t4_still_busy", bus.busy, 1);
    ack_at(base + 1, 3);
    check("t4_done", bus.done, 1);
    check("t4_no_spurious", bus.spurious_ack, 0);

    // Fill the FIFO with no ack; ready drops when full, returns on next pop.
    for (int i = 0; i <= DEPTH; i++) push(DW'(8'h50 + i), RETRIES + 1);
    check("t5_ready_full", bus.cmd_ready, 0);
    check("t5_pending_full", bus.pending_cnt, DEPTH);
    g = 0;
    while (bus.pending_cnt == DEPTH && g < 60) begin
      step();
      g++;
    end
    check("t5_pending_after_pop", bus.pending_cnt, DEPTH - 1);
    check("t5_ready_resumed", bus.cmd_ready, 1);
    do_reset();

    // Reset during WAIT, then ack in the first post-reset cycle.
    base = n_req;
    push(8'h77, 1);
    wait_req(base + 1);
    step();
    check("t6_in_wait", bus.busy, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_req_data", bus.req_data, 0);
    check("t6_rst_pending", bus.pending_cnt, 0);
    check("t6_rst_ready", bus.cmd_ready, 0);
    step();
    check("t6_rst_no_done", bus.done, 0);
    rst_n = 1'b1;
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    check("t6_post_spurious", bus.spurious_ack, 1);
    check("t6_post_no_done", bus.done, 0);
    check("t6_post_no_to", bus.timeout, 0);
    check("t6_post_idle", bus.busy, 0);
    check("t6_post_ready", bus.cmd_ready, 1);
    step();
    check("t6_spurious_pulse", bus.spurious_ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
